// File: rtl/bus_timing_if.sv
// bus_timing_if: CPU/DMA bus-cycle control and status signals of bus_timing.
interface bus_timing_if;
  logic [1:0] speed_i;
  logic       run_i;
  logic       spi_req_i;
  logic       cpu_clk_o;
  logic       cpu_be_o;
  logic       cpu_setup_o;
  logic       cpu_commit_o;
  logic       spi_grant_o;
  logic       spi_ack_o;
  logic       halted_o;
  modport master (
    output speed_i, run_i, spi_req_i,
    input  cpu_clk_o, cpu_be_o, cpu_setup_o, cpu_commit_o, spi_grant_o, spi_ack_o, halted_o
  );
  modport slave (
    input  speed_i, run_i, spi_req_i,
    output cpu_clk_o, cpu_be_o, cpu_setup_o, cpu_commit_o, spi_grant_o, spi_ack_o, halted_o
  );
endinterface

// File: rtl/bus_timing.sv
// bus_timing: derives 65xx PHI2, bus enable and phase strobes, interleaving DMA and halt cycles.
module bus_timing #(
  parameter int CYCLE_CLKS = 16,
  parameter int CNT_W      = $clog2(CYCLE_CLKS)
) (
  input  logic clk16_i,
  input  logic reset_nai,
  bus_timing_if.slave bus
);
  typedef enum logic [1:0] {K_CPU = 2'd0, K_DMA = 2'd1, K_IDLE = 2'd2} kind_t;
  localparam logic [CNT_W:0] CYC = CYCLE_CLKS[CNT_W:0];
  kind_t            kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       speed_q, speed_d;
  logic [CNT_W:0]   p_q, p_d;
  logic [CNT_W-1:0] last_q, last_d, half_d;
  logic             bnd;
  logic [6:0]       out_q, out_d;
  always_ff @(posedge clk16_i or negedge reset_nai) begin
    if (!reset_nai) begin
      kind_q  <= K_CPU;
      cnt_q   <= '0;
      speed_q <= 2'd0;
      out_q   <= '0;
    end else begin
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
      out_q   <= out_d;
    end
  end
  // speed and kind are only resampled at the boundary, so P never changes mid-cycle
  always_comb begin
    p_q     = CYC >> speed_q;
    last_q  = CNT_W'(p_q - 1'b1);
    bnd     = cnt_q == last_q;
    cnt_d   = bnd ? '0 : cnt_q + 1'b1;
    speed_d = bnd ? bus.speed_i : speed_q;
    kind_d  = !bnd ? kind_q :
              (bus.spi_req_i && kind_q != K_DMA) ? K_DMA :
              bus.run_i ? K_CPU : K_IDLE;
  end
  // outputs decode the incoming (cnt, kind) so the registers line up with cnt
  always_comb begin
    p_d    = CYC >> speed_d;
    half_d = CNT_W'(p_d >> 1);
    last_d = CNT_W'(p_d - 1'b1);
    out_d  = {kind_d == K_CPU && cnt_d >= half_d,
              kind_d == K_CPU,
              kind_d == K_CPU && cnt_d == half_d - 1'b1,
              kind_d == K_CPU && cnt_d == last_d,
              kind_d == K_DMA,
              kind_d == K_DMA && cnt_d == last_d,
              kind_d == K_IDLE};
  end
  assign {bus.cpu_clk_o, bus.cpu_be_o, bus.cpu_setup_o, bus.cpu_commit_o,
          bus.spi_grant_o, bus.spi_ack_o, bus.halted_o} = out_q;
endmodule

// File: tb/tb_bus_timing.sv
// tb_bus_timing: scenario tasks plus randomized traffic against a cycle-schedule queue model.
module tb_bus_timing;
  localparam int CYC = 16;
  logic clk16_i = 1'b0;
  logic reset_nai = 1'b1;
  bus_timing_if bus();
  bus_timing #(.CYCLE_CLKS(CYC)) dut (.clk16_i(clk16_i), .reset_nai(reset_nai), .bus(bus));
  always #5 clk16_i = ~clk16_i;

  int checks = 0;
  int failures = 0;
  logic [6:0] exp_cur = '0;
  logic [6:0] exp_q[$];
  int last_kind = 0;
  int mk;
  logic [6:0] got;
  assign got = {bus.cpu_clk_o, bus.cpu_be_o, bus.cpu_setup_o, bus.cpu_commit_o,
                bus.spi_grant_o, bus.spi_ack_o, bus.halted_o};

  // kind: 0 CPU, 1 DMA, 2 IDLE; queues the expected outputs of clocks start..p-1 of one cycle
  task automatic push_cycle(input int kind, input int p, input int start);
    for (int i = start; i < p; i++)
      exp_q.push_back({kind == 0 && i >= p / 2, kind == 0, kind == 0 && i == p / 2 - 1,
                       kind == 0 && i == p - 1, kind == 1, kind == 1 && i == p - 1, kind == 2});
  endtask

  always begin
    @(posedge clk16_i or negedge reset_nai);
    if (!reset_nai) begin
      exp_q.delete();
      exp_cur = '0;
      last_kind = 0;
      push_cycle(0, CYC, 1);
    end else begin
      if (exp_q.size() == 0) begin
        mk = (bus.spi_req_i && last_kind != 1) ? 1 : bus.run_i ? 0 : 2;
        last_kind = mk;
        push_cycle(mk, CYC >> bus.speed_i, 0);
      end
      exp_cur = exp_q.pop_front();
    end
  end

  task automatic test_reset();
    int hi = 0;
    bus.speed_i = 2'd0; bus.run_i = 1'b1; bus.spi_req_i = 1'b0;
    #1 reset_nai = 1'b0;
    repeat (3) @(negedge clk16_i);
    checks++;
    if (got !== 7'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", got, 7'd0); end
    reset_nai = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk16_i);
      checks++;
      if (got !== exp_cur) begin failures++; $display("FAIL reset_model clk=%0d got=%b exp=%b", i, got, exp_cur); end
      if (i == 7) begin
        checks++;
        if (bus.cpu_setup_o !== 1'b1) begin failures++; $display("FAIL reset_first_setup got=%b exp=1", bus.cpu_setup_o); end
      end
      if (i == 15) begin
        checks++;
        if (bus.cpu_commit_o !== 1'b1) begin failures++; $display("FAIL reset_first_commit got=%b exp=1", bus.cpu_commit_o); end
      end
      if (i >= 16 && i < 32) hi += int'(bus.cpu_clk_o);
      checks++;
      if (bus.cpu_be_o !== 1'b1) begin failures++; $display("FAIL reset_be clk=%0d got=%b exp=1", i, bus.cpu_be_o); end
    end
    checks++;
    if (hi != 8) begin failures++; $display("FAIL reset_phi2_high got=%0d exp=8", hi); end
  endtask

  task automatic test_speed_change();
    int n;
    int first = -1;
    int ncommit = 0;
    for (n = 0; n < 40 && bus.cpu_commit_o !== 1'b1; n++) @(negedge clk16_i);
    checks++;
    if (bus.cpu_commit_o !== 1'b1) begin failures++; $display("FAIL speed_wait_commit got=%b exp=1", bus.cpu_commit_o); end
    repeat (6) @(negedge clk16_i);
    bus.speed_i = 2'd2;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk16_i);
      checks++;
      if (got !== exp_cur) begin failures++; $display("FAIL speed_model clk=%0d got=%b exp=%b", i, got, exp_cur); end
      if (bus.cpu_commit_o === 1'b1) begin
        if (first < 0) first = i;
        ncommit++;
      end
    end
    checks++;
    if (first != 10) begin failures++; $display("FAIL speed_first_commit got=%0d exp=10", first); end
    checks++;
    if (ncommit != 6) begin failures++; $display("FAIL speed_commit_count got=%0d exp=6", ncommit); end
  endtask

  task automatic test_dma_held();
    int glen = 0;
    int runs = 0;
    int n;
    bus.speed_i = 2'd0; bus.run_i = 1'b1; bus.spi_req_i = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk16_i);
      checks++;
      if (got !== exp_cur) begin failures++; $display("FAIL dma_model clk=%0d got=%b exp=%b", i, got, exp_cur); end
      if (bus.spi_grant_o === 1'b1) begin
        glen++;
        if (bus.cpu_be_o !== 1'b0 || bus.cpu_clk_o !== 1'b0) begin
          checks++; failures++;
          $display("FAIL dma_bus_released be=%b clk=%b exp=0", bus.cpu_be_o, bus.cpu_clk_o);
        end
        if (bus.spi_ack_o === 1'b1) begin
          checks++;
          if (glen != 16) begin failures++; $display("FAIL dma_ack_pos got=%0d exp=16", glen); end
        end
      end else if (glen > 0) begin
        checks++;
        if (glen != 16 || bus.cpu_be_o !== 1'b1) begin
          failures++; $display("FAIL dma_grant_len got=%0d be=%b exp=16 be=1", glen, bus.cpu_be_o);
        end
        glen = 0;
        runs++;
      end
    end
    checks++;
    if (runs < 3) begin failures++; $display("FAIL dma_runs got=%0d exp>=3", runs); end
    for (n = 0; n < 40 && bus.spi_ack_o !== 1'b1; n++) @(negedge clk16_i);
    @(negedge clk16_i);
    bus.spi_req_i = 1'b0;
  endtask

  task automatic test_halt_dma();
    int acks = 0;
    int halted = 0;
    int n;
    logic ack_prev = 1'b0;
    bus.run_i = 1'b0; bus.spi_req_i = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk16_i);
      checks++;
      if (got !== exp_cur) begin failures++; $display("FAIL halt_model clk=%0d got=%b exp=%b", i, got, exp_cur); end
      if (ack_prev) bus.spi_req_i = 1'b0;
      ack_prev = bus.spi_ack_o;
      acks += int'(bus.spi_ack_o);
      halted += int'(bus.halted_o);
    end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL halt_ack_count got=%0d exp=1", acks); end
    checks++;
    if (halted < 40 || bus.cpu_be_o !== 1'b0) begin failures++; $display("FAIL halt_idle halted=%0d be=%b exp>=40 be=0", halted, bus.cpu_be_o); end
    bus.run_i = 1'b1;
    for (n = 0; n < 20 && bus.cpu_be_o !== 1'b1; n++) begin
      @(negedge clk16_i);
      checks++;
      if (got !== exp_cur) begin failures++; $display("FAIL resume_model got=%b exp=%b", got, exp_cur); end
    end
    checks++;
    if (bus.cpu_be_o !== 1'b1 || bus.halted_o !== 1'b0) begin failures++; $display("FAIL resume_cpu be=%b halted=%b exp be=1 halted=0", bus.cpu_be_o, bus.halted_o); end
  endtask

  task automatic test_reset_dma();
    int n;
    int acks = 0;
    bus.speed_i = 2'd0; bus.run_i = 1'b1; bus.spi_req_i = 1'b1;
    for (n = 0; n < 40 && bus.spi_grant_o !== 1'b1; n++) @(negedge clk16_i);
    checks++;
    if (bus.spi_grant_o !== 1'b1) begin failures++; $display("FAIL rdma_grant got=%b exp=1", bus.spi_grant_o); end
    repeat (7) begin
      @(negedge clk16_i);
      acks += int'(bus.spi_ack_o);
    end
    #2 reset_nai = 1'b0;
    #1;
    checks++;
    if (got !== 7'd0) begin failures++; $display("FAIL rdma_async_clear got=%b exp=%b", got, 7'd0); end
    bus.spi_req_i = 1'b0;
    repeat (3) begin
      @(negedge clk16_i);
      acks += int'(bus.spi_ack_o);
    end
    reset_nai = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk16_i);
      checks++;
      if (got !== exp_cur) begin failures++; $display("FAIL rdma_model clk=%0d got=%b exp=%b", i, got, exp_cur); end
      acks += int'(bus.spi_ack_o);
      if (i == 15) begin
        checks++;
        if (bus.cpu_commit_o !== 1'b1) begin failures++; $display("FAIL rdma_restart_commit got=%b exp=1", bus.cpu_commit_o); end
      end
    end
    checks++;
    if (acks != 0) begin failures++; $display("FAIL rdma_no_ack got=%0d exp=0", acks); end
  endtask

  task automatic test_simultaneous();
    int n;
    bus.run_i = 1'b1; bus.spi_req_i = 1'b0;
    for (n = 0; n < 40 && bus.cpu_commit_o !== 1'b1; n++) @(negedge clk16_i);
    checks++;
    if (bus.cpu_commit_o !== 1'b1) begin failures++; $display("FAIL simul_wait_commit got=%b exp=1", bus.cpu_commit_o); end
    bus.spi_req_i = 1'b1; bus.run_i = 1'b0; bus.speed_i = 2'd3;
    @(negedge clk16_i);
    checks++;
    if (got !== 7'b0000100) begin failures++; $display("FAIL simul_dma0 got=%b exp=%b", got, 7'b0000100); end
    @(negedge clk16_i);
    checks++;
    if (got !== 7'b0000110) begin failures++; $display("FAIL simul_dma1 got=%b exp=%b", got, 7'b0000110); end
    @(negedge clk16_i);
    bus.spi_req_i = 1'b0;
    checks++;
    if (got !== 7'b0000001) begin failures++; $display("FAIL simul_idle0 got=%b exp=%b", got, 7'b0000001); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk16_i);
      checks++;
      if (got !== exp_cur) begin failures++; $display("FAIL simul_model clk=%0d got=%b exp=%b", i, got, exp_cur); end
    end
    bus.run_i = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk16_i);
      if (!reset_nai) reset_nai = 1'b1;
      checks++;
      if (got !== exp_cur) begin failures++; $display("FAIL random_model clk=%0d got=%b exp=%b", i, got, exp_cur); end
      if ($urandom_range(0, 15) == 0) bus.speed_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) bus.run_i = ~bus.run_i;
      if (bus.spi_req_i && bus.spi_ack_o && $urandom_range(0, 1) == 0) bus.spi_req_i = 1'b0;
      else if (!bus.spi_req_i && $urandom_range(0, 7) == 0) bus.spi_req_i = 1'b1;
      if ($urandom_range(0, 499) == 0) begin
        #3 reset_nai = 1'b0;
        #1;
        checks++;
        if (got !== 7'd0) begin failures++; $display("FAIL random_reset got=%b exp=%b", got, 7'd0); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_speed_change();
    test_dma_held();
    test_halt_dma();
    test_reset_dma();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
